// File: rtl/dco_loop_filter.sv
// Digital PLL loop filter: PI controller driving a DCO control word,
// with phase accumulator reference, anti-windup and lock detection.
module dco_loop_filter #(
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 6,
    parameter int DCTRL_MIN  = -32768,
    parameter int DCTRL_MAX  = 32767,
    parameter int DCTRL_RST  = 0,
    parameter int LOCK_TOL   = 4,
    parameter int UNLOCK_TOL = 16,
    parameter int LOCK_CNT   = 64
) (
    input  logic               refclk,
    input  logic               resetn,
    input  logic               en,
    input  logic signed [31:0] fcw,
    input  logic signed [31:0] dctrl_init,
    input  logic signed [31:0] dco_phase,
    output logic signed [31:0] dctrl,
    output logic signed [31:0] phase_err,
    output logic               locked,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);
    localparam logic signed [49:0] U_MAX = 50'(DCTRL_MAX);
    localparam logic signed [49:0] U_MIN = 50'(DCTRL_MIN);
    localparam logic signed [47:0] I_MAX = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [47:0] I_MIN = -48'sh7FFF_FFFF_FFFF - 48'sd1;

    state_t             state_q, state_d;
    logic               locked_q, locked_d;
    logic signed [31:0] ref_q, ref_d;
    logic signed [31:0] err_q, err_d;
    logic signed [47:0] integ_q, integ_d;
    logic signed [31:0] dctrl_q, dctrl_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic signed [31:0] err_n;
    logic signed [48:0] isum;
    logic signed [47:0] integ_n;
    logic signed [49:0] u;
    logic signed [31:0] err_abs;
    logic               err_min;
    logic               in_lock;
    logic               out_unlock;
    logic               hold;

    always_comb begin
        err_n = ref_q - dco_phase;
        isum  = 49'(integ_q) + 49'(err_q);
        if (isum[48] != isum[47]) begin
            integ_n = isum[48] ? I_MIN : I_MAX;
        end else begin
            integ_n = isum[47:0];
        end
        u = 50'(dctrl_init)
          + 50'(err_q >>> KP_SHIFT)
          + 50'(integ_n >>> KI_SHIFT);
        // -2^31 has no positive magnitude; keep it out of both windows
        err_min    = (err_q == 32'sh8000_0000);
        err_abs    = err_q[31] ? -err_q : err_q;
        in_lock    = !err_min && (err_abs <= LOCK_TOL);
        out_unlock = err_min || (err_abs > UNLOCK_TOL);
        hold = ((u > U_MAX) && (err_q > 0))
            || ((u < U_MIN) && (err_q < 0));
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        err_d   = err_q;
        integ_d = integ_q;
        dctrl_d = dctrl_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            dctrl_d = dctrl_init;
            integ_d = '0;
            err_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ref_d   = dco_phase + fcw;
                    err_d   = '0;
                    integ_d = '0;
                    cnt_d   = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE, LOCKED: begin
                    err_d = err_n;
                    ref_d = ref_q + fcw;
                    if (!hold) begin
                        integ_d = integ_n;
                    end
                    if (u > U_MAX) begin
                        dctrl_d = 32'(DCTRL_MAX);
                    end else if (u < U_MIN) begin
                        dctrl_d = 32'(DCTRL_MIN);
                    end else begin
                        dctrl_d = u[31:0];
                    end
                    if (state_q == ACQUIRE) begin
                        if (!in_lock) begin
                            cnt_d = '0;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_d == CNT_MAX) begin
                            state_d = LOCKED;
                        end
                    end else if (out_unlock) begin
                        cnt_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            ref_q    <= '0;
            err_q    <= '0;
            integ_q  <= '0;
            dctrl_q  <= 32'(DCTRL_RST);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            ref_q    <= ref_d;
            err_q    <= err_d;
            integ_q  <= integ_d;
            dctrl_q  <= dctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dctrl     = dctrl_q;
    assign phase_err = err_q;
    assign locked    = locked_q;
    assign state     = state_q;

endmodule

// File: doc/dco_loop_filter.md
DCO_LOOP_FILTER -- requirements
Module: dco_loop_filter

Interface
REQ-001 The block SHALL have parameter KP_SHIFT, default 2, proportional gain as 2^-KP_SHIFT.
REQ-002 The block SHALL have parameter KI_SHIFT, default 6, integral gain as 2^-KI_SHIFT.
REQ-003 The block SHALL have parameters DCTRL_MIN and DCTRL_MAX, defaults -32768 and 32767, output saturation bounds.
REQ-004 The block SHALL have parameter DCTRL_RST, default 0, dctrl value while in reset.
REQ-005 The block SHALL have parameters LOCK_TOL, UNLOCK_TOL and LOCK_CNT, defaults 4, 16 and 64: the lock window, the unlock window and the consecutive in-window count.
REQ-006 Port refclk: input, 1 bit, sole clock; all state updates on posedge.
REQ-007 Port resetn: input, 1 bit, asynchronous active-low reset.
REQ-008 Port en: input, 1 bit, loop enable.
REQ-009 Port fcw: input, 32 bit signed, expected DCO phase advance per refclk, in dco_phase units.
REQ-010 Port dctrl_init: input, 32 bit signed, open-loop DCO code (centre code).
REQ-011 Port dco_phase: input, 32 bit signed, sampled DCO phase from the DCO stage; modular 32-bit.
REQ-012 Port dctrl: output, 32 bit signed, registered DCO control word.
REQ-013 Port phase_err: output, 32 bit signed, registered phase error err_q.
REQ-014 Port locked: output, 1 bit, registered lock flag.
REQ-015 Port state: output, 2 bit; IDLE=0, ACQUIRE=1, LOCKED=2; 3 is unused.

Function
REQ-016 The FSM SHALL have the states IDLE, ACQUIRE and LOCKED.
REQ-017 When en=0 in any state, the next edge SHALL give state=IDLE, locked=0, dctrl=dctrl_init, integ=0, err_q=0 and lock count 0.
REQ-018 When in IDLE with en=1, the next edge SHALL give ref_phase=dco_phase+fcw, err_q=0, integ=0 and state=ACQUIRE, with dctrl unchanged.
REQ-019 In ACQUIRE or LOCKED, each edge SHALL compute err=ref_phase-dco_phase (32-bit wrapping, signed), then set err_q<=err and ref_phase<=ref_phase+fcw (32-bit wrapping).
REQ-020 In ACQUIRE or LOCKED, each edge SHALL compute the integrator candidate integ_n=integ+err_q as a 48-bit signed value, saturating at the 48-bit limits.
REQ-021 The control candidate SHALL be u=dctrl_init+(err_q>>>KP_SHIFT)+(integ_n>>>KI_SHIFT), computed in at least 50-bit signed arithmetic with arithmetic shifts.
REQ-022 The output SHALL be dctrl<=clamp(u,DCTRL_MIN,DCTRL_MAX).
REQ-023 Anti-windup: integ SHALL hold its value when u>DCTRL_MAX and err_q>0, or when u<DCTRL_MIN and err_q<0; otherwise integ<=integ_n.
REQ-024 Latency: a dco_phase sampled at edge n SHALL affect phase_err at n+1 and dctrl at n+2.
REQ-025 In ACQUIRE, the lock count SHALL increment (saturating at LOCK_CNT) while |err_q|<=LOCK_TOL, and SHALL clear to 0 otherwise.
REQ-026 In ACQUIRE, on the edge where the count would reach LOCK_CNT, the block SHALL give state=LOCKED and locked=1.
REQ-027 In LOCKED, if |err_q|>UNLOCK_TOL, the next edge SHALL give state=ACQUIRE, locked=0 and count 0; filter updates SHALL continue uninterrupted.
REQ-028 |x| for x=-2^31 SHALL be treated as out of every window.
REQ-029 The output locked SHALL equal (state==LOCKED) at all times.

Reset
REQ-030 With resetn=0, the block SHALL immediately force state=IDLE, dctrl=DCTRL_RST, phase_err=0, locked=0, ref_phase=0, integ=0 and count 0, independent of refclk.
REQ-031 Reset asserted mid-ACQUIRE or mid-LOCKED SHALL discard all filter state; after release the block SHALL restart via IDLE per REQ-017/018.

Verification
REQ-032 Reset: pulse resetn low with no refclk -> dctrl=0, phase_err=0, locked=0 and state=0 immediately.
REQ-033 Ideal track: en=1, fcw=1000, dctrl_init=100, dco_phase advancing 1000/edge -> phase_err=0, dctrl=100 constant; locked rises on the 64th ACQUIRE edge after the first err_q evaluation.
REQ-034 Offset step: with the same setup, dco_phase lags the ideal by a constant 64 -> err_q=64; the first dctrl=100+16+1=117; dctrl then rises by 1 every edge (integral 64/edge >>> 6).
REQ-035 Saturation: a phase error of 2^20 -> dctrl=32767 and integ frozen; when the error is removed, dctrl returns below DCTRL_MAX without windup delay.
REQ-036 Wrap-around: ref_phase at 0x7FFFFFF0, fcw=0x20 and dco_phase wrapping identically -> err_q=0 across the wrap, with no spurious unlock.
REQ-037 Unlock and disable: in LOCKED, a single err_q=100 -> locked=0 and state=1 the next edge; en dropped -> state=0 and dctrl=dctrl_init the next edge.
